pc_sequencer: RTL and testbench

// Parametrised program-counter sequencer for the pipelined CPU fetch stage.
// It is the next generation of the PC/flag control unit and adds:
// - configurable PC width, instruction step and reset vector;
// - a run/halt state machine with a start handshake and a pipeline stall;
// - zero and negative flags, with JEQ/JNE/JLT branches;
// - absolute or PC-relative targets, and an optional CALL/RET stack.
//

---
 rtl/pc_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch-stage program counter with run/halt control, Z/N flags,
//            conditional branches and optional CALL/RET stack
//            (enabled by defining PC_CALL_STACK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int              PC_W        = 32,
    parameter int              IMM_W       = 18,
    parameter int              STEP        = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              REL_BRANCH  = 0,
    parameter int              STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             FlagsWrite,
    input  logic             ZeroFlagIn,
    input  logic             NegFlagIn,
    input  logic [2:0]       Id,
    input  logic [IMM_W-1:0] Imm,
    output logic [PC_W-1:0]  PCNext,
    output logic             ZeroFlagOut,
    output logic             NegFlagOut,
    output logic             running,
    output logic             EndFlag,
    output logic             taken,
    output logic             stack_err
);

    localparam logic [2:0] c_op_end  = 3'b001;
    localparam logic [2:0] c_op_call = 3'b010;
    localparam logic [2:0] c_op_ret  = 3'b011;
    localparam logic [2:0] c_op_jne  = 3'b100;
    localparam logic [2:0] c_op_jlt  = 3'b101;
    localparam logic [2:0] c_op_jmp  = 3'b110;
    localparam logic [2:0] c_op_jeq  = 3'b111;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_halt = 2'd2;

    logic [1:0]      r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_zf;
    logic            r_nf;
    logic [PC_W-1:0] w_seq_pc;
    logic [PC_W-1:0] w_imm_ext;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_nxt;
    logic            w_halt_req;
    logic            w_adv;

    assign w_seq_pc = r_pc + PC_W'(STEP);
    assign w_adv    = (r_state == c_st_run) && !stall;

    generate
        if (IMM_W >= PC_W) begin : g_imm_trunc
            assign w_imm_ext = Imm[PC_W-1:0];
        end else if (REL_BRANCH != 0) begin : g_imm_sext
            assign w_imm_ext = {{(PC_W-IMM_W){Imm[IMM_W-1]}}, Imm};
        end else begin : g_imm_zext
            assign w_imm_ext = {{(PC_W-IMM_W){1'b0}}, Imm};
        end

        if (REL_BRANCH != 0) begin : g_tgt_rel
            assign w_target = r_pc + w_imm_ext;
        end else begin : g_tgt_abs
            assign w_target = w_imm_ext;
        end
    endgenerate

`ifdef PC_CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0] r_stack [STACK_DEPTH];
    logic [SP_W-1:0] r_sp;
    logic            r_stack_err;
    logic [SP_W-1:0] w_sp_m1;
    logic            w_stk_full;
    logic            w_stk_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_stk_fault;

    assign w_sp_m1     = r_sp - 1'b1;
    assign w_stk_full  = (r_sp == SP_W'(STACK_DEPTH));
    assign w_stk_empty = (r_sp == '0);
    assign stack_err   = r_stack_err;
`else
    assign stack_err   = 1'b0;
`endif

    always_comb begin
        w_pc_nxt   = w_seq_pc;
        w_halt_req = 1'b0;
`ifdef PC_CALL_STACK_EN
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_stk_fault = 1'b0;
`endif
        case (Id)
            c_op_end: begin
                w_pc_nxt   = r_pc;
                w_halt_req = 1'b1;
            end
            c_op_jne: if (!r_zf) w_pc_nxt = w_target;
            c_op_jlt: if (r_nf)  w_pc_nxt = w_target;
            c_op_jmp: w_pc_nxt = w_target;
            c_op_jeq: if (r_zf)  w_pc_nxt = w_target;
`ifdef PC_CALL_STACK_EN
            // A stack fault leaves the PC where it is and stops the machine.
            c_op_call: begin
                if (w_stk_full) begin
                    w_pc_nxt    = r_pc;
                    w_stk_fault = 1'b1;
                    w_halt_req  = 1'b1;
                end else begin
                    w_pc_nxt = w_target;
                    w_push   = 1'b1;
                end
            end
            c_op_ret: begin
                if (w_stk_empty) begin
                    w_pc_nxt    = r_pc;
                    w_stk_fault = 1'b1;
                    w_halt_req  = 1'b1;
                end else begin
                    w_pc_nxt = r_stack[w_sp_m1[IDX_W-1:0]];
                    w_pop    = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    assign taken = w_adv && (Id != c_op_end) && (w_pc_nxt != w_seq_pc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
            r_pc    <= RESET_PC;
        end else if (!stall) begin
            case (r_state)
                c_st_idle: if (start) r_state <= c_st_run;
                c_st_run: begin
                    r_pc <= w_pc_nxt;
                    if (w_halt_req) r_state <= c_st_halt;
                end
                c_st_halt: begin
                    if (start) begin
                        r_state <= c_st_run;
                        r_pc    <= RESET_PC;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Flags are independent of the run state and of stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_zf <= 1'b0;
            r_nf <= 1'b0;
        end else if (FlagsWrite) begin
            r_zf <= ZeroFlagIn;
            r_nf <= NegFlagIn;
        end
    end

`ifdef PC_CALL_STACK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sp        <= '0;
            r_stack_err <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
        end else if (!stall) begin
            if ((r_state == c_st_halt) && start) begin
                r_sp        <= '0;
                r_stack_err <= 1'b0;
            end else if (r_state == c_st_run) begin
                if (w_push) begin
                    r_stack[r_sp[IDX_W-1:0]] <= w_seq_pc;
                    r_sp                     <= r_sp + 1'b1;
                end else if (w_pop) begin
                    r_sp <= w_sp_m1;
                end
                if (w_stk_fault) r_stack_err <= 1'b1;
            end
        end
    end
`endif

    assign PCNext      = r_pc;
    assign ZeroFlagOut = r_zf;
    assign NegFlagOut  = r_nf;
    assign running     = (r_state == c_st_run);
    assign EndFlag     = (r_state == c_st_halt);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed vector table plus hand sequences for pc_sequencer
//            (absolute and PC-relative builds; stack when PC_CALL_STACK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [2:0] NOP = 3'b000, ENDI = 3'b001, CALL = 3'b010, RET = 3'b011;
    localparam logic [2:0] JNE = 3'b100, JLT = 3'b101, JMP = 3'b110, JEQ = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stall, fw, zin, nin;
    logic [2:0]  id;
    logic [17:0] imm;

    logic [31:0] pc, pc_r;
    logic        zf, nf, run, endf, tk, serr;
    logic        zf_r, nf_r, run_r, endf_r, tk_r, serr_r;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .FlagsWrite(fw), .ZeroFlagIn(zin), .NegFlagIn(nin), .Id(id), .Imm(imm),
        .PCNext(pc), .ZeroFlagOut(zf), .NegFlagOut(nf), .running(run),
        .EndFlag(endf), .taken(tk), .stack_err(serr)
    );

    pc_sequencer #(.REL_BRANCH(1)) dut_rel (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .FlagsWrite(fw), .ZeroFlagIn(zin), .NegFlagIn(nin), .Id(id), .Imm(imm),
        .PCNext(pc_r), .ZeroFlagOut(zf_r), .NegFlagOut(nf_r), .running(run_r),
        .EndFlag(endf_r), .taken(tk_r), .stack_err(serr_r)
    );

    typedef struct {
        logic        st, sl, fw, z, n;
        logic [2:0]  id;
        logic [17:0] imm;
        logic        e_tk;
        logic [31:0] e_pc;
        logic        e_run, e_end, e_z, e_n;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(input logic st, sl, f, z, n, input logic [2:0] op,
                                input logic [17:0] im, input logic etk,
                                input logic [31:0] epc, input logic er, ee, ez, en);
        vec_t v;
        v.st = st; v.sl = sl; v.fw = f; v.z = z; v.n = n; v.id = op; v.imm = im;
        v.e_tk = etk; v.e_pc = epc; v.e_run = er; v.e_end = ee; v.e_z = ez; v.e_n = en;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic st, sl, f, z, n, input logic [2:0] op, input logic [17:0] im);
        start = st; stall = sl; fw = f; zin = z; nin = n; id = op; imm = im;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, 0, NOP, '0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        apply(0, 0, 0, 0, 0, NOP, '0);
        repeat (2) tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_flags", {30'b0, zf, nf}, 32'h0);
        chk("rst_state", {30'b0, run, endf}, 32'h0);
        chk("rst_taken_err", {30'b0, tk, serr}, 32'h0);
        reset = 1'b1;

        vecs[0]  = mk(1,0,0,0,0, NOP, 18'h0,     0, 32'h0,     1,0,0,0);
        vecs[1]  = mk(0,0,0,0,0, NOP, 18'h0,     0, 32'h4,     1,0,0,0);
        vecs[2]  = mk(0,0,0,0,0, NOP, 18'h0,     0, 32'h8,     1,0,0,0);
        vecs[3]  = mk(0,0,0,0,0, NOP, 18'h0,     0, 32'hC,     1,0,0,0);
        vecs[4]  = mk(0,0,1,1,0, NOP, 18'h0,     0, 32'h10,    1,0,1,0);
        vecs[5]  = mk(0,0,0,0,0, JEQ, 18'h40,    1, 32'h40,    1,0,1,0);
        vecs[6]  = mk(0,0,1,0,0, NOP, 18'h0,     0, 32'h44,    1,0,0,0);
        vecs[7]  = mk(0,0,0,0,0, JEQ, 18'h80,    0, 32'h48,    1,0,0,0);
        vecs[8]  = mk(0,0,0,0,0, JNE, 18'h80,    1, 32'h80,    1,0,0,0);
        vecs[9]  = mk(0,0,1,1,0, JEQ, 18'h200,   0, 32'h84,    1,0,1,0);
        vecs[10] = mk(0,0,0,0,0, JEQ, 18'h10,    1, 32'h10,    1,0,1,0);
        vecs[11] = mk(0,0,1,0,1, JLT, 18'h300,   0, 32'h14,    1,0,0,1);
        vecs[12] = mk(0,0,0,0,0, JLT, 18'h300,   1, 32'h300,   1,0,0,1);
        vecs[13] = mk(0,0,0,0,0, JMP, 18'h3FFFF, 1, 32'h3FFFF, 1,0,0,1);
        vecs[14] = mk(0,0,0,0,0, NOP, 18'h0,     0, 32'h40003, 1,0,0,1);
        vecs[15] = mk(0,0,0,0,0, JMP, 18'h20,    1, 32'h20,    1,0,0,1);
        vecs[16] = mk(0,1,0,0,0, JMP, 18'h100,   0, 32'h20,    1,0,0,1);
        vecs[17] = mk(0,1,1,1,0, JMP, 18'h100,   0, 32'h20,    1,0,1,0);
        vecs[18] = mk(0,1,0,0,0, JMP, 18'h100,   0, 32'h20,    1,0,1,0);
        vecs[19] = mk(0,0,0,0,0, JMP, 18'h100,   1, 32'h100,   1,0,1,0);
        vecs[20] = mk(0,0,0,0,0, JMP, 18'h20,    1, 32'h20,    1,0,1,0);
        vecs[21] = mk(0,0,0,0,0, ENDI,18'h0,     0, 32'h20,    0,1,1,0);
        vecs[22] = mk(0,0,0,0,0, NOP, 18'h0,     0, 32'h20,    0,1,1,0);
        vecs[23] = mk(1,0,0,0,0, NOP, 18'h0,     0, 32'h0,     1,0,1,0);
        vecs[24] = mk(0,0,0,0,0, NOP, 18'h0,     0, 32'h4,     1,0,1,0);
        vecs[25] = mk(1,0,0,0,0, NOP, 18'h0,     0, 32'h8,     1,0,1,0);

        for (int i = 0; i < 26; i++) begin
            apply(vecs[i].st, vecs[i].sl, vecs[i].fw, vecs[i].z, vecs[i].n, vecs[i].id, vecs[i].imm);
            chk($sformatf("v%0d_taken", i), {31'b0, tk}, {31'b0, vecs[i].e_tk});
            tick();
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_run_end", i), {30'b0, run, endf}, {30'b0, vecs[i].e_run, vecs[i].e_end});
            chk($sformatf("v%0d_flags", i), {30'b0, zf, nf}, {30'b0, vecs[i].e_z, vecs[i].e_n});
        end

        // Asynchronous reset in the middle of a cycle while running.
        apply(0, 0, 0, 0, 0, NOP, '0);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_state", {29'b0, run, endf, zf}, 32'h0);
        tick();
        reset = 1'b1;

        // PC-relative build: negative offset and wrap through 2^32.
        apply(1, 0, 0, 0, 0, NOP, '0); tick();
        chk("rel_start_pc", pc_r, 32'h0);
        apply(0, 0, 0, 0, 0, JMP, 18'h100);
        chk("rel_fwd_taken", {31'b0, tk_r}, 32'h1);
        tick();
        chk("rel_fwd_pc", pc_r, 32'h100);
        apply(0, 0, 0, 0, 0, JMP, 18'h3FFF0);
        chk("rel_back_taken", {31'b0, tk_r}, 32'h1);
        chk("abs_same_imm_taken", {31'b0, tk}, 32'h1);
        tick();
        chk("rel_back_pc", pc_r, 32'hF0);
        chk("abs_zext_pc", pc, 32'h3FFF0);
        apply(0, 0, 0, 0, 0, JMP, 18'h3FF0C); tick();
        chk("rel_top_pc", pc_r, 32'hFFFF_FFFC);
        apply(0, 0, 0, 0, 0, NOP, '0);
        chk("wrap_taken", {31'b0, tk_r}, 32'h0);
        tick();
        chk("wrap_pc", pc_r, 32'h0);

        // CALL/RET.
        do_reset();
        apply(1, 0, 0, 0, 0, NOP, '0); tick();
`ifdef PC_CALL_STACK_EN
        for (int k = 1; k <= 4; k++) begin
            apply(0, 0, 0, 0, 0, CALL, 18'(k * 'h100)); tick();
            chk($sformatf("call%0d_pc", k), pc, 32'(k * 'h100));
        end
        chk("call4_err", {31'b0, serr}, 32'h0);
        apply(0, 0, 0, 0, 0, CALL, 18'h500); tick();
        chk("call5_pc", pc, 32'h400);
        chk("call5_err_halt", {29'b0, serr, run, endf}, 32'b101);
        apply(1, 0, 0, 0, 0, NOP, '0); tick();
        chk("restart_pc_err", {pc[30:0], serr}, 32'h0);
        apply(0, 0, 0, 0, 0, RET, '0); tick();
        chk("ret_empty_pc", pc, 32'h0);
        chk("ret_empty_err_halt", {29'b0, serr, run, endf}, 32'b101);
        apply(1, 0, 0, 0, 0, NOP, '0); tick();
        apply(0, 0, 0, 0, 0, CALL, 18'h100); tick();
        apply(0, 0, 0, 0, 0, RET, '0);
        chk("ret_taken", {31'b0, tk}, 32'h1);
        tick();
        chk("ret_pc", pc, 32'h4);
        chk("ret_err", {31'b0, serr}, 32'h0);
`else
        apply(0, 0, 0, 0, 0, CALL, 18'h100);
        chk("call_nop_taken", {31'b0, tk}, 32'h0);
        tick();
        chk("call_nop_pc", pc, 32'h4);
        apply(0, 0, 0, 0, 0, RET, '0); tick();
        chk("ret_nop_pc", pc, 32'h8);
        chk("ret_nop_err_run", {30'b0, serr, run}, 32'b01);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
